// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   arb_state_e : transaction state (IDLE / WRITE / READ)
//   REQ_CORE / REQ_LOADER : requester indices (load/store unit, loader)
//   rr_pick()   : two-way round-robin winner selection
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef struct packed {
    logic valid;  // at least one requester is asking
    logic idx;    // winning requester index
  } rr_pick_t;

  // A lone requester always wins; on a tie the one that did not win last time goes.
  function automatic rr_pick_t rr_pick(input logic req0, input logic req1,
                                       input logic last_grant);
    rr_pick_t p;
    p.valid = req0 | req1;
    if (req0 && req1) begin
      p.idx = ~last_grant;
    end else if (req1) begin
      p.idx = REQ_LOADER;
    end else begin
      p.idx = REQ_CORE;
    end
    return p;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port between the
// CPU load/store unit (requester 0) and the program/data loader (requester 1).
// One transaction is in flight at a time; reads are timed by an internal
// latency counter so requesters only see gnt / rvalid pulses.
//   clk, rst            : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN : request, write flag, word address, write data
//   gntN                : one-cycle pulse, request accepted
//   rvalidN/rdataN      : one-cycle read-data pulse; rdataN holds until next read
//   busy                : transaction in flight
//   mem_addr/mem_wdata/mem_we/mem_rdata : memory port
// RD_LAT must lie in 1..15.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  rr_pick_t          pick;
  logic              sel_we;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= REQ_LOADER;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    sel_we       = 1'b0;
    pick         = rr_pick(req0, req1, last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (pick.valid) begin
          last_grant_d = pick.idx;
          if (pick.idx == REQ_LOADER) begin
            gnt1_d      = 1'b1;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
            sel_we      = we1;
          end else begin
            gnt0_d      = 1'b1;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            sel_we      = we0;
          end
          if (sel_we) begin
            mem_we_d = 1'b1;
            state_d  = WRITE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = READ;
          end
        end
      end

      // The single mem_we cycle was issued on the grant edge.
      WRITE: begin
        state_d = IDLE;
      end

      // last_grant_q still names the owner of the read in flight.
      READ: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (last_grant_q == REQ_LOADER) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_rdata;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT = 3, 1, 7), each with its
// own BRAM model. Expected read data comes from a reference memory that is
// updated whenever the bench issues a write.
module tb_dmem_arbiter;

  localparam int NI = 3;

  logic clk;
  logic rst;

  logic [NI-1:0]       req0_v, req1_v, we0_v, we1_v;
  logic [NI-1:0][31:0] addr0_v, addr1_v, wdata0_v, wdata1_v;
  logic [NI-1:0]       gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, busy_v, mem_we_v;
  logic [NI-1:0][31:0] rdata0_v, rdata1_v, mem_addr_v, mem_wdata_v, mem_rdata_v;

  logic [31:0] ref_mem [NI][256];

  int n_checks;
  int n_fail;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 3;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [31:0] init_val(input int g, input int a);
    return (32'(a) * 32'h9E37_79B1) ^ (32'(g) << 24) ^ 32'h0000_A5A5;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 7);
    logic [31:0] bram [256];
    logic [31:0] pipe [8];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0_v[g]),
      .we0      (we0_v[g]),
      .addr0    (addr0_v[g]),
      .wdata0   (wdata0_v[g]),
      .req1     (req1_v[g]),
      .we1      (we1_v[g]),
      .addr1    (addr1_v[g]),
      .wdata1   (wdata1_v[g]),
      .gnt0     (gnt0_v[g]),
      .gnt1     (gnt1_v[g]),
      .rvalid0  (rvalid0_v[g]),
      .rvalid1  (rvalid1_v[g]),
      .rdata0   (rdata0_v[g]),
      .rdata1   (rdata1_v[g]),
      .busy     (busy_v[g]),
      .mem_addr (mem_addr_v[g]),
      .mem_wdata(mem_wdata_v[g]),
      .mem_we   (mem_we_v[g]),
      .mem_rdata(mem_rdata_v[g])
    );

    initial begin
      for (int a = 0; a < 256; a++) bram[a] = init_val(g, a);
    end

    // BRAM: address in, data out LAT cycles later.
    always @(posedge clk) begin
      pipe[0] <= bram[mem_addr_v[g][7:0]];
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      if (mem_we_v[g]) bram[mem_addr_v[g][7:0]] = mem_wdata_v[g];
    end

    if (LAT == 1) begin : g_lat1
      assign mem_rdata_v[g] = bram[mem_addr_v[g][7:0]];
    end else begin : g_latn
      assign mem_rdata_v[g] = pipe[LAT-2];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic gnt_of(input int i, input int r);
    return (r == 0) ? gnt0_v[i] : gnt1_v[i];
  endfunction

  function automatic logic rvalid_of(input int i, input int r);
    return (r == 0) ? rvalid0_v[i] : rvalid1_v[i];
  endfunction

  function automatic logic [31:0] rdata_of(input int i, input int r);
    return (r == 0) ? rdata0_v[i] : rdata1_v[i];
  endfunction

  task automatic drive(input int i, input int r, input logic en, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (r == 0) begin
      req0_v[i] = en; we0_v[i] = we; addr0_v[i] = a; wdata0_v[i] = d;
    end else begin
      req1_v[i] = en; we1_v[i] = we; addr1_v[i] = a; wdata1_v[i] = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
    addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({gnt0_v[i], gnt1_v[i], rvalid0_v[i], rvalid1_v[i], busy_v[i], mem_we_v[i]} !== 6'b0 ||
          rdata0_v[i] !== 32'h0 || rdata1_v[i] !== 32'h0 ||
          mem_addr_v[i] !== 32'h0 || mem_wdata_v[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: ctl=%b rd0=%h rd1=%h ma=%h mwd=%h, required all zero",
                 i, {gnt0_v[i], gnt1_v[i], rvalid0_v[i], rvalid1_v[i], busy_v[i], mem_we_v[i]},
                 rdata0_v[i], rdata1_v[i], mem_addr_v[i], mem_wdata_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  // Single write from an idle arbiter.
  task automatic write_txn(input int i, input int r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(i, r, 1'b1, 1'b1, a, d);
    @(negedge clk);
    n_checks++;
    if (gnt_of(i, r) !== 1'b1 || gnt_of(i, 1 - r) !== 1'b0 || busy_v[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_gnt inst%0d req%0d: gnt0=%b gnt1=%b busy=%b, required gnt%0d only, busy=1",
               i, r, gnt0_v[i], gnt1_v[i], busy_v[i], r);
    end
    n_checks++;
    if (mem_we_v[i] !== 1'b1 || mem_addr_v[i] !== a || mem_wdata_v[i] !== d) begin
      n_fail++;
      $display("FAIL wr_port inst%0d: we=%b addr=%h wdata=%h, required we=1 addr=%h wdata=%h",
               i, mem_we_v[i], mem_addr_v[i], mem_wdata_v[i], a, d);
    end
    drive(i, r, 1'b0, 1'b0, $urandom(), $urandom());
    ref_mem[i][a[7:0]] = d;
    @(negedge clk);
    n_checks++;
    if (mem_we_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || gnt_of(i, r) !== 1'b0 ||
        rvalid0_v[i] !== 1'b0 || rvalid1_v[i] !== 1'b0 || mem_addr_v[i] !== a) begin
      n_fail++;
      $display("FAIL wr_done inst%0d: we=%b busy=%b gnt=%b rv=%b%b addr=%h, required 0 0 0 00 addr=%h",
               i, mem_we_v[i], busy_v[i], gnt_of(i, r), rvalid0_v[i], rvalid1_v[i], mem_addr_v[i], a);
    end
  endtask

  // Single read from an idle arbiter; checks latency, data and side effects.
  task automatic read_txn(input int i, input int r, input logic [31:0] a);
    logic [31:0] exp_d;
    logic [31:0] other_d;
    int          n;
    logic        stray;
    exp_d   = ref_mem[i][a[7:0]];
    other_d = rdata_of(i, 1 - r);
    @(negedge clk);
    drive(i, r, 1'b1, 1'b0, a, $urandom());
    @(negedge clk);
    n_checks++;
    if (gnt_of(i, r) !== 1'b1 || mem_we_v[i] !== 1'b0 || mem_addr_v[i] !== a || busy_v[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_gnt inst%0d req%0d: gnt=%b we=%b addr=%h busy=%b, required 1 0 %h 1",
               i, r, gnt_of(i, r), mem_we_v[i], mem_addr_v[i], busy_v[i], a);
    end
    drive(i, r, 1'b0, 1'b0, $urandom(), $urandom());
    n = 0;
    stray = 1'b0;
    while (rvalid_of(i, r) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if ((gnt0_v[i] | gnt1_v[i] | rvalid_of(i, 1 - r) | mem_we_v[i]) !== 1'b0) stray = 1'b1;
      if (mem_addr_v[i] !== a) stray = 1'b1;
    end
    n_checks++;
    if (n != lat_of(i)) begin
      n_fail++;
      $display("FAIL rd_latency inst%0d req%0d: rvalid %0d cycles after gnt, required %0d",
               i, r, n, lat_of(i));
    end
    n_checks++;
    if (rdata_of(i, r) !== exp_d || busy_v[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_data inst%0d req%0d addr=%h: rdata=%h busy=%b, required %h busy=0",
               i, r, a, rdata_of(i, r), busy_v[i], exp_d);
    end
    n_checks++;
    if (stray || rdata_of(i, 1 - r) !== other_d) begin
      n_fail++;
      $display("FAIL rd_side inst%0d req%0d: stray=%b other_rdata=%h, required stray=0 other=%h",
               i, r, stray, rdata_of(i, 1 - r), other_d);
    end
    @(negedge clk);
    n_checks++;
    if (rvalid_of(i, r) !== 1'b0 || rdata_of(i, r) !== exp_d) begin
      n_fail++;
      $display("FAIL rd_hold inst%0d req%0d: rvalid=%b rdata=%h, required 0 %h",
               i, r, rvalid_of(i, r), rdata_of(i, r), exp_d);
    end
  endtask

  task automatic test_write();
    write_txn(0, 0, 32'h10, 32'hDEAD_BEEF);
  endtask

  task automatic test_read();
    read_txn(0, 1, 32'h10);
  endtask

  // Both requesters hold write requests: grants must alternate every 2 cycles.
  task automatic test_alternate();
    logic [31:0] a [2];
    logic [31:0] d [2];
    int exp_r, last_c, ng, w;
    logic stray;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a[r] = 32'($urandom_range(32'h20, 32'h3F)) + 32'(r * 32'h20);
      d[r] = $urandom();
      drive(0, r, 1'b1, 1'b1, a[r], d[r]);
    end
    exp_r = 0; last_c = 0; ng = 0; stray = 1'b0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      @(negedge clk);
      if ((rvalid0_v[0] | rvalid1_v[0]) !== 1'b0) stray = 1'b1;
      if ((gnt0_v[0] | gnt1_v[0]) === 1'b1) begin
        w = gnt1_v[0] ? 1 : 0;
        n_checks++;
        if (gnt0_v[0] !== (exp_r == 0) || gnt1_v[0] !== (exp_r == 1)) begin
          n_fail++;
          $display("FAIL rr_order grant#%0d: gnt0=%b gnt1=%b, required gnt%0d", ng, gnt0_v[0], gnt1_v[0], exp_r);
        end
        if (ng > 0) begin
          n_checks++;
          if (c - last_c != 2) begin
            n_fail++;
            $display("FAIL rr_spacing grant#%0d: %0d cycles since previous, required 2", ng, c - last_c);
          end
        end
        n_checks++;
        if (mem_we_v[0] !== 1'b1 || mem_addr_v[0] !== a[w] || mem_wdata_v[0] !== d[w]) begin
          n_fail++;
          $display("FAIL rr_port grant#%0d: we=%b addr=%h wdata=%h, required 1 %h %h",
                   ng, mem_we_v[0], mem_addr_v[0], mem_wdata_v[0], a[w], d[w]);
        end
        ref_mem[0][a[w][7:0]] = d[w];
        a[w] = 32'($urandom_range(32'h20, 32'h3F)) + 32'(w * 32'h20);
        d[w] = $urandom();
        drive(0, w, 1'b1, 1'b1, a[w], d[w]);
        exp_r  = 1 - exp_r;
        last_c = c;
        ng++;
      end
    end
    n_checks++;
    if (ng != 8 || stray) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants, stray rvalid=%b, required 8 and 0", ng, stray);
    end
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
  endtask

  // req1 raised while req0's read is in flight.
  task automatic test_pending();
    logic [31:0] a0, a1, e0, e1;
    int cyc, rv0, g1, rv1;
    a0 = 32'h44; a1 = 32'h88;
    e0 = ref_mem[0][a0[7:0]];
    e1 = ref_mem[0][a1[7:0]];
    @(negedge clk);
    drive(0, 0, 1'b1, 1'b0, a0, '0);
    @(negedge clk);
    n_checks++;
    if (gnt0_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_gnt0: gnt0=%b, required 1", gnt0_v[0]);
    end
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    drive(0, 1, 1'b1, 1'b0, a1, '0);
    cyc = 2; rv0 = -1; g1 = -1; rv1 = -1;
    for (int c = 0; c < 30 && rv1 < 0; c++) begin
      @(negedge clk);
      cyc++;
      if (rvalid0_v[0] === 1'b1) rv0 = cyc;
      if (gnt1_v[0] === 1'b1 && g1 < 0) begin
        g1 = cyc;
        drive(0, 1, 1'b0, 1'b0, '0, '0);
      end
      if (rvalid1_v[0] === 1'b1) rv1 = cyc;
    end
    n_checks++;
    if (rv0 != 1 + lat_of(0) || g1 != rv0 + 1 || rv1 != g1 + lat_of(0)) begin
      n_fail++;
      $display("FAIL pend_timing: rvalid0@%0d gnt1@%0d rvalid1@%0d, required %0d %0d %0d",
               rv0, g1, rv1, 1 + lat_of(0), 2 + lat_of(0), 2 + 2 * lat_of(0));
    end
    n_checks++;
    if (rdata0_v[0] !== e0 || rdata1_v[0] !== e1) begin
      n_fail++;
      $display("FAIL pend_data: rdata0=%h rdata1=%h, required %h %h", rdata0_v[0], rdata1_v[0], e0, e1);
    end
    @(negedge clk);
  endtask

  // Reset lands while the read counter is at 2.
  task automatic test_reset_mid();
    logic [31:0] a;
    logic seen;
    a = 32'($urandom_range(0, 255));
    @(negedge clk);
    drive(0, 0, 1'b1, 1'b0, a, '0);
    @(negedge clk);
    n_checks++;
    if (gnt0_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt: gnt0=%b, required 1", gnt0_v[0]);
    end
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({gnt0_v[0], gnt1_v[0], rvalid0_v[0], rvalid1_v[0], busy_v[0], mem_we_v[0]} !== 6'b0 ||
        rdata0_v[0] !== 32'h0 || rdata1_v[0] !== 32'h0 || mem_addr_v[0] !== 32'h0 ||
        mem_wdata_v[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_state: ctl=%b rd0=%h ma=%h, required all zero",
               {gnt0_v[0], gnt1_v[0], rvalid0_v[0], rvalid1_v[0], busy_v[0], mem_we_v[0]},
               rdata0_v[0], mem_addr_v[0]);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ((rvalid0_v[0] | rvalid1_v[0] | busy_v[0]) !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_quiet: rvalid/busy seen after reset, required none");
    end
    read_txn(0, 0, a);
  endtask

  // RD_LAT = 1 and RD_LAT = 7 instances.
  task automatic test_sweep();
    logic [31:0] a, d;
    for (int i = 1; i < NI; i++) begin
      for (int r = 0; r < 2; r++) begin
        a = 32'($urandom_range(0, 255));
        d = $urandom();
        write_txn(i, r, a, d);
        read_txn(i, 1 - r, a);
      end
      read_txn(i, 0, 32'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_random();
    int r;
    logic [31:0] a;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 20; k++) begin
        r = int'($urandom_range(0, 1));
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) write_txn(i, r, a, $urandom());
        else read_txn(i, r, a);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
    addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0;
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 256; a++) ref_mem[i][a] = init_val(i, a);

    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_pending();
    test_reset_mid();
    test_sweep();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory BRAM port (addr / wdata / we / 32-bit rdata, fixed read latency) between two requesters.
- Requester 0 is the CPU core's load/store unit; requester 1 is the program/data loader (UART or host side).
- Serialises accesses with round-robin arbitration, one transaction in flight at a time.
- Runs a read-latency counter so requesters see a clean gnt/rvalid handshake and never count memory wait cycles themselves.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- DATA_W, 32, data width.
- RD_LAT, 3, memory cycles from address presented to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req0 / req1  in  1  access request from requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data valid.
- rdata0 / rdata1  out  DATA_W  read data; holds its value until the next read for that requester.
- busy  out  1  transaction in flight (state != IDLE).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE, latency counter = 0, last_grant = 1 (so requester 0 wins the first tie).
- States:
  - IDLE: no transaction.
  - WRITE: one cycle with mem_we = 1.
  - READ: address held while the latency counter runs.
- Request sampling:
  - req is sampled only in IDLE.
  - A requester holds req, we, addr and wdata stable until it sees gnt; the arbiter registers them on the grant edge.
- Arbitration:
  - Only one req high in IDLE: that requester wins.
  - Both high: the requester other than last_grant wins.
  - last_grant updates on every grant.
- Grant edge (IDLE with a winner):
  - gnt_w = 1 for exactly one cycle.
  - mem_addr and mem_wdata are loaded from the winner.
  - If we: mem_we = 1 and next state = WRITE.
  - Else: mem_we = 0, counter = 1, next state = READ.
- WRITE: on the next edge mem_we = 0 and next state = IDLE. No rvalid is produced for a write.
- READ:
  - mem_addr is held constant.
  - counter < RD_LAT: counter increments.
  - counter == RD_LAT: rdata_w <= mem_rdata, rvalid_w = 1 for one cycle, state = IDLE.
- Read timing: req sampled at edge t → gnt high in cycle t+1 → rvalid high in cycle t+RD_LAT+1, with data.
- Throughput:
  - The earliest next grant is sampled at the edge where the state is back in IDLE.
  - Back-to-back writes: one grant every 2 cycles.
  - Back-to-back reads: one grant every RD_LAT+1 cycles.
- Requests arriving while busy:
  - Not lost if req stays high; they are considered in IDLE.
  - A req that drops before IDLE is never serviced.
- mem_addr and mem_wdata keep their last values in IDLE. Only mem_we qualifies a write.
- Reset mid-operation:
  - An in-flight read is abandoned; no rvalid is produced.
  - An in-flight write: mem_we drops on the reset edge.
  - Outputs return to reset values.
- The counter is $clog2(RD_LAT+1) bits wide; no wrap-around is possible within the legal range.
- Addresses are passed through unmodified; no address arithmetic.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE, WRITE, READ);
  - requester index constants REQ_CORE = 0, REQ_LOADER = 1;
  - function rr_pick(req0, req1, last_grant) returning the winner index and a valid bit.
- Single module; no sub-module needed. The arbitration is the rr_pick function.

Test Plan:
- Reset, then req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF:
  - next cycle gnt0 = 1, mem_we = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF;
  - following cycle mem_we = 0 and busy = 0.
- req1 read with addr1 = 0x10, memory model with RD_LAT = 3 returning stored data:
  - gnt1 at t+1;
  - rvalid1 at t+4 with rdata1 = 0xDEADBEEF;
  - no rvalid0.
- req0 and req1 both held high, both writes, from reset:
  - grants alternate gnt0, gnt1, gnt0, gnt1, spaced 2 cycles apart.
- req0 read pending and req1 raised mid-READ:
  - gnt1 only after rvalid0, at the first IDLE edge;
  - rdata0 unchanged by the later req1 access.
- Assert rst at counter == 2 during a read:
  - no rvalid ever issues; all outputs 0 the next cycle;
  - a new req0 is granted normally after reset.
- Parameter sweep RD_LAT = 1 and RD_LAT = 7:
  - rvalid arrives exactly RD_LAT cycles after gnt;
  - data matches the memory model.
